fwd_scoreboard_ex: RTL

- Parametrised successor to the single-level EX forwarding control.
- Tracks destination writes of up to DEPTH in-flight instructions beyond EX in an internal shift register that stays aligned with pipeline advance.
- For NUM_SRC source operands of the EX instruction, selects the youngest forwarding stage. Raises a load-use stall when that producer's result is not yet available.
- Sits beside the EX stage. Drives the operand muxes and the pipeline hold/bubble logic.

---
 rtl/fwd_scoreboard_ex.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fwd_scoreboard_ex.sv
// ============================================================================
// Module   : fwd_scoreboard_ex
// Brief    : Multi-stage EX forwarding scoreboard with load-use stall detection.
//            Optional perf counters: define FWD_SCOREBOARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fwd_scoreboard_ex #(
  parameter  int ADDR_W           = 5,
  parameter  int DEPTH            = 3,
  parameter  int NUM_SRC          = 2,
  parameter  int LOAD_READY_STAGE = 2,
  localparam int SEL_W            = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      advance,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_wen,
  input  logic [ADDR_W-1:0]         issue_waddr,
  input  logic                      issue_late,
  input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      hazard_stall
`ifdef FWD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]               perf_fwd_cnt,
  output logic [31:0]               perf_stall_cnt
`endif
);

  // Index 0 holds stage 1 (EX/MEM); index DEPTH-1 holds the oldest stage.
  logic [DEPTH-1:0]  r_valid;
  logic [DEPTH-1:0]  r_late;
  logic [ADDR_W-1:0] r_waddr [DEPTH];

  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic [NUM_SRC-1:0]       w_stall_req;
  logic                     w_stall;

  always_comb begin
    logic [ADDR_W-1:0] w_src;
    logic [SEL_W-1:0]  w_hit_sel;
    logic              w_hit;
    logic              w_hit_rdy;
    w_fwd_sel   = '0;
    w_stall_req = '0;
    w_src       = '0;
    w_hit_sel   = '0;
    w_hit       = 1'b0;
    w_hit_rdy   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_src     = ex_src_addr[i*ADDR_W +: ADDR_W];
      w_hit_sel = '0;
      w_hit     = 1'b0;
      w_hit_rdy = 1'b0;
      // Scan oldest to youngest so the youngest match is the one that sticks.
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_valid[k-1] && (r_waddr[k-1] == w_src) && (w_src != '0)) begin
          w_hit     = 1'b1;
          w_hit_sel = SEL_W'(k);
          w_hit_rdy = !r_late[k-1] || (k >= LOAD_READY_STAGE);
        end
      end
      if (w_hit && w_hit_rdy) begin
        w_fwd_sel[i*SEL_W +: SEL_W] = w_hit_sel;
      end
      w_stall_req[i] = w_hit && !w_hit_rdy;
    end
  end

  assign w_stall      = issue_valid && (|w_stall_req);
  assign fwd_sel      = w_fwd_sel;
  assign hazard_stall = w_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_late  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_waddr[k] <= '0;
      end
    end else if (advance) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        r_valid[k] <= r_valid[k-1];
        r_late[k]  <= r_late[k-1];
        r_waddr[k] <= r_waddr[k-1];
      end
      // A stalled or flushed EX instruction leaves a bubble behind it.
      r_valid[0] <= issue_valid && issue_wen && !w_stall && !flush;
      r_late[0]  <= issue_late;
      r_waddr[0] <= issue_waddr;
    end
  end

`ifdef FWD_SCOREBOARD_PERF_EN
  logic r_unused_perf;
  logic w_fwd_event;

  assign w_fwd_event   = issue_valid && !w_stall && (|w_fwd_sel);
  assign r_unused_perf = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fwd_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_fwd_event && (perf_fwd_cnt != 32'hFFFF_FFFF)) begin
        perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
      end
      if (w_stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire
